// File: rtl/reg_file_mp.sv
// Multi-ported register file: two combinational read ports, two write ports,
// optional hardwired-zero register 0, optional write-to-read bypass and a sequential clear sweep.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data_a,
  output logic [DATA_W-1:0] read_data_b,
  output logic [DATA_W-1:0] register_v0,
  input  logic [ADDR_W-1:0] write_reg0,
  input  logic              write_enable0,
  input  logic [DATA_W-1:0] write_data0,
  input  logic [ADDR_W-1:0] write_reg1,
  input  logic              write_enable1,
  input  logic [DATA_W-1:0] write_data1,
  input  logic              clear_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // FSM state and sweep pointer kept together so checkers can bind to one signal.
  typedef struct packed {
    state_t            state;
    logic [ADDR_W-1:0] cnt;
  } fsm_t;

  fsm_t              fsm;
  logic [DATA_W-1:0] regs [DEPTH];

  logic wr_ok0;
  logic wr_ok1;
  logic byp_ok;

  // Writes to register 0 are dropped at the source so neither storage nor bypass sees them.
  assign wr_ok0 = write_enable0 && !(ZERO_REG && (write_reg0 == '0));
  assign wr_ok1 = write_enable1 && !(ZERO_REG && (write_reg1 == '0));
  assign byp_ok = BYPASS && !reset && clk_enable && (fsm.state == IDLE);

  // clear_req/busy: a request is taken on any enabled edge in IDLE with clear_req=1; busy
  // stays high for exactly DEPTH enabled edges and further requests are ignored while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm.state <= IDLE;
      fsm.cnt   <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clk_enable) begin
      if (fsm.state == IDLE) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_ok1 && (write_reg1 == ADDR_W'(i))) begin
            regs[i] <= write_data1;
          end else if (wr_ok0 && (write_reg0 == ADDR_W'(i))) begin
            regs[i] <= write_data0;
          end
        end
        if (clear_req) begin
          fsm.state <= CLEAR;
          fsm.cnt   <= '0;
          busy      <= 1'b1;
        end
      end else begin
        regs[fsm.cnt] <= '0;
        fsm.cnt       <= fsm.cnt + ADDR_W'(1);
        if (fsm.cnt == LAST) begin
          fsm.state <= IDLE;
          busy      <= 1'b0;
        end
      end
    end
  end

  // Port 1 is applied last so it wins over port 0 on an address collision.
  always_comb begin
    read_data_a = regs[read_reg1];
    if (byp_ok && wr_ok0 && (write_reg0 == read_reg1)) read_data_a = write_data0;
    if (byp_ok && wr_ok1 && (write_reg1 == read_reg1)) read_data_a = write_data1;
    if (ZERO_REG && (read_reg1 == '0)) read_data_a = '0;
  end

  always_comb begin
    read_data_b = regs[read_reg2];
    if (byp_ok && wr_ok0 && (write_reg0 == read_reg2)) read_data_b = write_data0;
    if (byp_ok && wr_ok1 && (write_reg1 == read_reg2)) read_data_b = write_data1;
    if (ZERO_REG && (read_reg2 == '0)) read_data_b = '0;
  end

  assign register_v0 = regs[2];

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: one bypassing and one non-bypassing instance share all inputs and
// are compared against an array-based model of the register file and its clear sweep.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_enable;
  logic          clear_req;
  logic [AW-1:0] read_reg1, read_reg2, write_reg0, write_reg1;
  logic          write_enable0, write_enable1;
  logic [DW-1:0] write_data0, write_data1;
  logic [DW-1:0] rda_b, rdb_b, v0_b, rda_n, rdb_n, v0_n;
  logic          busy_b, busy_n;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];
  bit            m_busy;
  int            m_cnt;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data_a(rda_b), .read_data_b(rdb_b), .register_v0(v0_b),
    .write_reg0(write_reg0), .write_enable0(write_enable0), .write_data0(write_data0),
    .write_reg1(write_reg1), .write_enable1(write_enable1), .write_data1(write_data1),
    .clear_req(clear_req), .busy(busy_b)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data_a(rda_n), .read_data_b(rdb_n), .register_v0(v0_n),
    .write_reg0(write_reg0), .write_enable0(write_enable0), .write_data0(write_data0),
    .write_reg1(write_reg1), .write_enable1(write_enable1), .write_data1(write_data1),
    .clear_req(clear_req), .busy(busy_n)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    m_busy = 1'b0;
    m_cnt  = 0;
  endtask

  // Applies one rising edge: writes in order port 0 then port 1 so port 1 wins.
  task automatic model_edge();
    if (!reset && clk_enable) begin
      if (!m_busy) begin
        if (write_enable0 && write_reg0 != 0) mem[write_reg0] = write_data0;
        if (write_enable1 && write_reg1 != 0) mem[write_reg1] = write_data1;
        if (clear_req) begin
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end else begin
        mem[m_cnt] = '0;
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_busy = 1'b0;
          m_cnt  = 0;
        end
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    logic [DW-1:0] v;
    v = mem[a];
    if (byp && !reset && clk_enable && !m_busy) begin
      if (write_enable0 && write_reg0 == a) v = write_data0;
      if (write_enable1 && write_reg1 == a) v = write_data1;
    end
    if (a == 0) v = '0;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    clk_enable    = 1'b1;
    clear_req     = 1'b0;
    write_enable0 = 1'b0;
    write_enable1 = 1'b0;
    write_reg0    = '0;
    write_reg1    = '0;
    write_data0   = '0;
    write_data1   = '0;
    read_reg1     = '0;
    read_reg2     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic fill();
    idle_inputs();
    for (int i = 0; i < DEPTH / 2; i++) begin
      write_enable0 = 1'b1; write_reg0 = AW'(2 * i);     write_data0 = $urandom | 32'h1;
      write_enable1 = 1'b1; write_reg1 = AW'(2 * i + 1); write_data1 = $urandom | 32'h1;
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      read_reg1 = AW'($urandom); read_reg2 = AW'($urandom);
      write_enable0 = 1'b1; write_reg0 = read_reg1; write_data0 = $urandom | 32'h1;
      clear_req = 1'b1;
      #1;
      checks++; if (rda_b !== '0) begin errors++; $display("FAIL reset_rda got %h exp 0", rda_b); end
      checks++; if (rdb_n !== '0) begin errors++; $display("FAIL reset_rdb got %h exp 0", rdb_n); end
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_b); end
      checks++; if (v0_b !== '0) begin errors++; $display("FAIL reset_v0 got %h exp 0", v0_b); end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    write_enable0 = 1'b1; write_reg0 = AW'(9); write_data0 = 32'h1234_5678;
    tick();
    idle_inputs();
    read_reg1 = AW'(9);
    #1;
    checks++; if (rda_n !== 32'h1234_5678) begin errors++; $display("FAIL first_write got %h exp 12345678", rda_n); end
    checks++; if (busy_n !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy_n); end
    tick();
  endtask

  task automatic test_bypass();
    idle_inputs();
    write_enable0 = 1'b1; write_reg0 = AW'(5); write_data0 = 32'hDEAD_BEEF;
    read_reg1 = AW'(5); read_reg2 = AW'(5);
    #1;
    checks++; if (rda_b !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same_cycle got %h exp deadbeef", rda_b); end
    checks++; if (rda_n !== exp_rd(5, 1'b0)) begin errors++; $display("FAIL nobypass_same_cycle got %h exp %h", rda_n, exp_rd(5, 1'b0)); end
    tick();
    idle_inputs();
    read_reg1 = AW'(5);
    #1;
    checks++; if (rda_n !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nobypass_next_cycle got %h exp deadbeef", rda_n); end
    checks++; if (rda_b !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_next_cycle got %h exp deadbeef", rda_b); end
    tick();
  endtask

  task automatic test_same_addr();
    idle_inputs();
    write_enable0 = 1'b1; write_reg0 = AW'(7); write_data0 = 32'h1111_1111;
    write_enable1 = 1'b1; write_reg1 = AW'(7); write_data1 = 32'h2222_2222;
    read_reg1 = AW'(7); read_reg2 = AW'(7);
    #1;
    checks++; if (rda_b !== 32'h2222_2222) begin errors++; $display("FAIL collide_bypass_a got %h exp 22222222", rda_b); end
    checks++; if (rdb_b !== 32'h2222_2222) begin errors++; $display("FAIL collide_bypass_b got %h exp 22222222", rdb_b); end
    tick();
    idle_inputs();
    read_reg2 = AW'(7);
    #1;
    checks++; if (rdb_n !== 32'h2222_2222) begin errors++; $display("FAIL collide_stored got %h exp 22222222", rdb_n); end
    tick();
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] old_v0;
    idle_inputs();
    old_v0 = mem[2];
    write_enable0 = 1'b1; write_reg0 = AW'(0); write_data0 = 32'hFFFF_FFFF;
    write_enable1 = 1'b1; write_reg1 = AW'(2); write_data1 = 32'h0000_ABCD;
    read_reg1 = AW'(0); read_reg2 = AW'(2);
    #1;
    checks++; if (rda_b !== '0) begin errors++; $display("FAIL zero_bypass got %h exp 0", rda_b); end
    checks++; if (rda_n !== '0) begin errors++; $display("FAIL zero_nobypass got %h exp 0", rda_n); end
    checks++; if (v0_b !== old_v0) begin errors++; $display("FAIL v0_not_bypassed got %h exp %h", v0_b, old_v0); end
    checks++; if (rdb_b !== 32'h0000_ABCD) begin errors++; $display("FAIL v0_reg_bypass got %h exp 0000abcd", rdb_b); end
    tick();
    idle_inputs();
    write_enable1 = 1'b1; write_reg1 = AW'(0); write_data1 = 32'h5555_AAAA;
    read_reg1 = AW'(0); read_reg2 = AW'(0);
    #1;
    checks++; if (rda_b !== '0) begin errors++; $display("FAIL zero_next_cycle got %h exp 0", rda_b); end
    checks++; if (rdb_b !== '0) begin errors++; $display("FAIL zero_port1_bypass got %h exp 0", rdb_b); end
    checks++; if (v0_b !== 32'h0000_ABCD) begin errors++; $display("FAIL v0_after got %h exp 0000abcd", v0_b); end
    checks++; if (v0_n !== 32'h0000_ABCD) begin errors++; $display("FAIL v0n_after got %h exp 0000abcd", v0_n); end
    tick();
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      clk_enable    = ($urandom_range(0, 7) != 0);
      clear_req     = 1'b0;
      read_reg1     = AW'($urandom);
      read_reg2     = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      write_enable0 = $urandom_range(0, 1) == 1;
      write_enable1 = $urandom_range(0, 1) == 1;
      write_reg0    = ($urandom_range(0, 2) == 0) ? read_reg1 : AW'($urandom_range(0, 7));
      write_reg1    = ($urandom_range(0, 2) == 0) ? write_reg0 : AW'($urandom);
      write_data0   = $urandom;
      write_data1   = $urandom;
      #1;
      checks++; if (rda_b !== exp_rd(read_reg1, 1'b1)) begin errors++; $display("FAIL rand_rda_b addr %0d got %h exp %h", read_reg1, rda_b, exp_rd(read_reg1, 1'b1)); end
      checks++; if (rdb_b !== exp_rd(read_reg2, 1'b1)) begin errors++; $display("FAIL rand_rdb_b addr %0d got %h exp %h", read_reg2, rdb_b, exp_rd(read_reg2, 1'b1)); end
      checks++; if (rda_n !== exp_rd(read_reg1, 1'b0)) begin errors++; $display("FAIL rand_rda_n addr %0d got %h exp %h", read_reg1, rda_n, exp_rd(read_reg1, 1'b0)); end
      checks++; if (rdb_n !== exp_rd(read_reg2, 1'b0)) begin errors++; $display("FAIL rand_rdb_n addr %0d got %h exp %h", read_reg2, rdb_n, exp_rd(read_reg2, 1'b0)); end
      checks++; if (v0_b !== mem[2]) begin errors++; $display("FAIL rand_v0 got %h exp %h", v0_b, mem[2]); end
      checks++; if (busy_b !== m_busy) begin errors++; $display("FAIL rand_busy got %b exp %b", busy_b, m_busy); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int n;
    fill();
    clear_req = 1'b1;
    write_enable0 = 1'b1; write_reg0 = AW'(3); write_data0 = 32'hCAFE_0003;
    #1;
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL clear_req_cycle_busy got %b exp 0", busy_b); end
    tick();
    n = 0;
    while (busy_b && n < 40) begin
      clear_req     = (m_cnt < DEPTH - 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
      write_enable0 = 1'b1; write_reg0 = AW'($urandom); write_data0 = $urandom | 32'h1;
      write_enable1 = 1'b1; write_reg1 = AW'($urandom); write_data1 = $urandom | 32'h1;
      read_reg1     = (n < 4) ? AW'(3) : write_reg0;
      read_reg2     = AW'(m_cnt);
      #1;
      checks++; if (rda_b !== exp_rd(read_reg1, 1'b1)) begin errors++; $display("FAIL sweep_rda addr %0d got %h exp %h", read_reg1, rda_b, exp_rd(read_reg1, 1'b1)); end
      checks++; if (rdb_n !== exp_rd(read_reg2, 1'b0)) begin errors++; $display("FAIL sweep_rdb addr %0d got %h exp %h", read_reg2, rdb_n, exp_rd(read_reg2, 1'b0)); end
      checks++; if (busy_n !== m_busy) begin errors++; $display("FAIL sweep_busy got %b exp %b", busy_n, m_busy); end
      tick();
      n++;
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL sweep_length got %0d exp %0d", n, DEPTH); end
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      read_reg1 = AW'(i); read_reg2 = AW'(i);
      #1;
      checks++; if (rda_b !== '0) begin errors++; $display("FAIL cleared_a addr %0d got %h exp 0", i, rda_b); end
      checks++; if (rdb_n !== '0) begin errors++; $display("FAIL cleared_b addr %0d got %h exp 0", i, rdb_n); end
    end
    tick();
  endtask

  task automatic test_clear_stall();
    int n;
    int stall;
    fill();
    clear_req = 1'b1;
    tick();
    idle_inputs();
    n = 0;
    stall = 0;
    while (busy_b && (n + stall) < 50) begin
      clk_enable    = !(n == 10 && stall < 3);
      clear_req     = (m_cnt < DEPTH - 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
      write_enable0 = 1'b1; write_reg0 = AW'(m_cnt); write_data0 = $urandom | 32'h1;
      read_reg1     = AW'(m_cnt);
      read_reg2     = AW'($urandom);
      #1;
      checks++; if (rda_b !== exp_rd(read_reg1, 1'b1)) begin errors++; $display("FAIL stall_rda addr %0d got %h exp %h", read_reg1, rda_b, exp_rd(read_reg1, 1'b1)); end
      checks++; if (rdb_n !== exp_rd(read_reg2, 1'b0)) begin errors++; $display("FAIL stall_rdb addr %0d got %h exp %h", read_reg2, rdb_n, exp_rd(read_reg2, 1'b0)); end
      checks++; if (busy_b !== m_busy) begin errors++; $display("FAIL stall_busy got %b exp %b", busy_b, m_busy); end
      tick();
      if (clk_enable) n++; else stall++;
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL stall_sweep_length got %0d exp %0d", n, DEPTH); end
    checks++; if (stall != 3) begin errors++; $display("FAIL stall_cycles got %0d exp 3", stall); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    fill();
    clear_req = 1'b1;
    tick();
    idle_inputs();
    repeat (10) tick();
    read_reg1 = AW'(20); read_reg2 = AW'(25);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b exp 0", busy_b); end
    checks++; if (rda_b !== '0) begin errors++; $display("FAIL async_reset_rda got %h exp 0", rda_b); end
    checks++; if (rdb_n !== '0) begin errors++; $display("FAIL async_reset_rdb got %h exp 0", rdb_n); end
    for (int i = 0; i < DEPTH; i++) begin
      read_reg1 = AW'(i); read_reg2 = AW'(DEPTH - 1 - i);
      #1;
      checks++; if (rda_b !== '0 || rdb_n !== '0) begin errors++; $display("FAIL reset_contents addr %0d got %h/%h exp 0", i, rda_b, rdb_n); end
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      read_reg1 = AW'($urandom); read_reg2 = AW'($urandom);
      #1;
      checks++; if (busy_b !== 1'b0 || busy_n !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b/%b exp 0", busy_b, busy_n); end
      checks++; if (rda_b !== exp_rd(read_reg1, 1'b1)) begin errors++; $display("FAIL post_reset_read got %h exp %h", rda_b, exp_rd(read_reg1, 1'b1)); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: bench did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_bypass();
    test_same_addr();
    test_zero_reg();
    test_random(200);
    test_clear();
    test_random(60);
    test_clear_stall();
    test_reset_mid_sweep();
    test_random(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
